alu_issue_stage: RTL and testbench

- Operand-issue stage directly upstream of the 8-bit ALU.
- Accepts decoded instructions over a valid/ready handshake and reads operands from an internal 8x8 register file.
- Registers OP/A/B into a one-entry issue register that drives the ALU inputs.
- On the following edge, writes the combinational ALU result back to rd, with bypass for back-to-back dependencies.

---
 rtl/alu_issue_stage.sv | 96 +++++++++
 tb/tb_alu_issue_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Operand-issue stage feeding the 8-bit ALU.
// Owns the register file, the issue register and the retire counter.
module alu_issue_stage #(
    parameter int NREG  = 8,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       IN_OP,
    input  logic [AW-1:0]    IN_RD,
    input  logic [AW-1:0]    IN_RS,
    input  logic [7:0]       IN_IMM,
    input  logic             IN_USE_IMM,
    input  logic             HOLD,
    output logic [3:0]       ALU_OP,
    output logic [7:0]       ALU_A,
    output logic [7:0]       ALU_B,
    input  logic [7:0]       ALU_RESULT,
    input  logic [AW-1:0]    DBG_ADDR,
    output logic [7:0]       DBG_DATA,
    output logic [CNT_W-1:0] RETIRE_CNT
);

    logic [7:0]    regs [NREG];
    logic          s1_v;
    logic [3:0]    s1_op;
    logic [AW-1:0] s1_rd;
    logic [7:0]    s1_a;
    logic [7:0]    s1_b;

    logic          writing;
    logic          retire;
    logic          wb;
    logic          accept;
    logic [7:0]    rd_val;
    logic [7:0]    rs_val;

    // Retire/writeback qualifiers and forwarded operand reads
    always_comb begin
        writing = (s1_op >= 4'd3) && (s1_op <= 4'd7);
        retire  = s1_v && !HOLD;
        wb      = retire && writing;
        accept  = IN_VALID && !HOLD;
        rd_val  = regs[IN_RD];
        rs_val  = regs[IN_RS];
        if (wb && (IN_RD == s1_rd)) rd_val = ALU_RESULT;
        if (wb && (IN_RS == s1_rd)) rs_val = ALU_RESULT;
    end

    // ALU drive is forced to zero whenever the issue slot is empty
    always_comb begin
        IN_READY = !HOLD;
        ALU_OP   = s1_v ? s1_op : 4'd0;
        ALU_A    = s1_v ? s1_a : 8'd0;
        ALU_B    = s1_v ? s1_b : 8'd0;
        DBG_DATA = regs[DBG_ADDR];
    end

    // Issue register: load on accept, bubble when idle, freeze on HOLD
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_v  <= 1'b0;
            s1_op <= '0;
            s1_rd <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
        end else if (!HOLD) begin
            s1_v <= IN_VALID;
            if (accept) begin
                s1_op <= IN_OP;
                s1_rd <= IN_RD;
                s1_a  <= rd_val;
                s1_b  <= IN_USE_IMM ? IN_IMM : rs_val;
            end
        end
    end

    // Register file writeback of the retiring instruction
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb) begin
            regs[s1_rd] <= ALU_RESULT;
        end
    end

    // Retire counter, wraps naturally at its width
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) RETIRE_CNT <= '0;
        else if (retire) RETIRE_CNT <= RETIRE_CNT + 1'b1;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed plan plus random traffic
// against an architectural model; a second DUT has a 4-bit counter.
module tb_alu_issue_stage;

    logic       CLK = 0;
    logic       RST_N = 0;
    logic       IN_VALID = 0;
    logic [3:0] IN_OP = 0;
    logic [2:0] IN_RD = 0;
    logic [2:0] IN_RS = 0;
    logic [7:0] IN_IMM = 0;
    logic       IN_USE_IMM = 0;
    logic       HOLD = 0;
    logic [2:0] DBG_ADDR = 0;

    logic        rdy, rdy4;
    logic [3:0]  aop, aop4;
    logic [7:0]  aa, ab, aa4, ab4;
    logic [7:0]  res, res4;
    logic [7:0]  dbg, dbg4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int total = 0;
    int bad = 0;

    // architectural model
    logic [7:0] m_regs [8];
    int         m_cnt;
    bit         p_v;
    logic [3:0] p_op;
    logic [2:0] p_rd;
    logic [7:0] p_a, p_b;

    always #5 CLK = ~CLK;

    function automatic logic [7:0] alu(input logic [3:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
        case (op)
            4'd3:    return a ^ b;
            4'd4:    return a + b;
            4'd5:    return a << b[2:0];
            4'd6:    return a >> b[2:0];
            4'd7:    return a & b;
            default: return (a | b) + 8'd1;
        endcase
    endfunction

    assign res  = alu(aop, aa, ab);
    assign res4 = alu(aop4, aa4, ab4);

    alu_issue_stage dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(rdy),
        .IN_OP(IN_OP), .IN_RD(IN_RD), .IN_RS(IN_RS),
        .IN_IMM(IN_IMM), .IN_USE_IMM(IN_USE_IMM),
        .HOLD(HOLD),
        .ALU_OP(aop), .ALU_A(aa), .ALU_B(ab), .ALU_RESULT(res),
        .DBG_ADDR(DBG_ADDR), .DBG_DATA(dbg),
        .RETIRE_CNT(cnt)
    );

    alu_issue_stage #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(rdy4),
        .IN_OP(IN_OP), .IN_RD(IN_RD), .IN_RS(IN_RS),
        .IN_IMM(IN_IMM), .IN_USE_IMM(IN_USE_IMM),
        .HOLD(HOLD),
        .ALU_OP(aop4), .ALU_A(aa4), .ALU_B(ab4), .ALU_RESULT(res4),
        .DBG_ADDR(DBG_ADDR), .DBG_DATA(dbg4),
        .RETIRE_CNT(cnt4)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_alu(input string tag);
        chk({tag, "_op"}, {12'd0, aop}, p_v ? {12'd0, p_op} : 16'd0);
        chk({tag, "_a"}, {8'd0, aa}, p_v ? {8'd0, p_a} : 16'd0);
        chk({tag, "_b"}, {8'd0, ab}, p_v ? {8'd0, p_b} : 16'd0);
        chk({tag, "_a4"}, {8'd0, aa4}, p_v ? {8'd0, p_a} : 16'd0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
        m_cnt = 0;
        p_v = 0;
        p_op = 0;
        p_rd = 0;
        p_a = 0;
        p_b = 0;
    endtask

    // one clock: drive at negedge, check pre-edge, advance model, check post
    task automatic cyc(input bit v, input logic [3:0] op,
                       input logic [2:0] rd, input logic [2:0] rs,
                       input logic [7:0] imm, input bit ui, input bit h);
        @(negedge CLK);
        IN_VALID = v;
        IN_OP = op;
        IN_RD = rd;
        IN_RS = rs;
        IN_IMM = imm;
        IN_USE_IMM = ui;
        HOLD = h;
        DBG_ADDR = 3'($urandom_range(0, 7));
        #1;
        chk("ready", {15'd0, rdy}, {15'd0, !h});
        chk("ready4", {15'd0, rdy4}, {15'd0, !h});
        chk("dbg_pre", {8'd0, dbg}, {8'd0, m_regs[DBG_ADDR]});
        chk_alu("pre");
        @(posedge CLK);
        if (!h) begin
            if (p_v) begin
                if (p_op >= 4'd3 && p_op <= 4'd7)
                    m_regs[p_rd] = alu(p_op, p_a, p_b);
                m_cnt++;
            end
            p_v = v;
            if (v) begin
                p_op = op;
                p_rd = rd;
                p_a = m_regs[rd];
                p_b = ui ? imm : m_regs[rs];
            end
        end
        #1;
        chk_alu("post");
        chk("cnt", cnt, 16'(m_cnt));
        chk("cnt4", {12'd0, cnt4}, 16'(m_cnt % 16));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic peek(input string tag, input logic [2:0] adr,
                        input logic [7:0] exp);
        @(negedge CLK);
        DBG_ADDR = adr;
        #1;
        chk(tag, {8'd0, dbg}, {8'd0, exp});
    endtask

    task automatic do_reset();
        #2;
        RST_N = 0;
        #1;
        chk("rst_op", {12'd0, aop}, 16'd0);
        chk("rst_a", {8'd0, aa}, 16'd0);
        chk("rst_b", {8'd0, ab}, 16'd0);
        chk("rst_cnt", cnt, 16'd0);
        chk("rst_cnt4", {12'd0, cnt4}, 16'd0);
        model_clear();
        @(negedge CLK);
        IN_VALID = 0;
        HOLD = 0;
        RST_N = 1;
        for (int i = 0; i < 8; i++) peek("rst_reg", 3'(i), 8'd0);
    endtask

    initial begin
        int c0;
        model_clear();
        do_reset();

        // back-to-back dependency
        cyc(1, 4'd4, 3'd1, 3'd0, 8'd5, 1, 0);
        cyc(1, 4'd4, 3'd1, 3'd0, 8'd3, 1, 0);
        chk("dep_a", {8'd0, aa}, 16'd5);
        idle();
        peek("dep_r1", 3'd1, 8'd8);
        chk("dep_cnt", cnt, 16'd2);

        // register-register with B bypass
        cyc(1, 4'd4, 3'd2, 3'd0, 8'h0F, 1, 0);
        cyc(1, 4'd4, 3'd3, 3'd0, 8'h3C, 1, 0);
        cyc(1, 4'd3, 3'd2, 3'd3, 8'hFF, 0, 0);
        cyc(1, 4'd7, 3'd3, 3'd2, 8'hFF, 0, 0);
        idle();
        peek("rr_r2", 3'd2, 8'h33);
        peek("rr_r3", 3'd3, 8'h30);

        // HOLD for three cycles with inc r4 in the issue register
        c0 = m_cnt;
        cyc(1, 4'd4, 3'd4, 3'd0, 8'd1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'd4, 3'd4, 3'd0, 8'd77, 1, 1);
            chk("hold_a", {8'd0, aa}, 16'd0);
            chk("hold_cnt", cnt, 16'(c0));
        end
        idle();
        idle();
        peek("hold_r4", 3'd4, 8'd1);
        chk("hold_cnt_done", cnt, 16'(c0 + 1));

        // non-writing opcodes
        c0 = m_cnt;
        cyc(1, 4'd0, 3'd5, 3'd1, 8'h11, 1, 0);
        cyc(1, 4'd9, 3'd5, 3'd1, 8'h22, 0, 0);
        idle();
        peek("nw_r5", 3'd5, 8'd0);
        chk("nw_cnt", cnt, 16'(c0 + 2));

        // counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++)
            cyc(1, 4'(i), 3'(i), 3'(i + 3), 8'(i * 7), 1, 0);
        idle();
        chk("wrap_cnt4", {12'd0, cnt4}, 16'd1);
        chk("wrap_cnt", cnt, 16'd17);

        // random traffic
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, 4'($urandom), 3'($urandom),
                3'($urandom), 8'($urandom), 1'($urandom),
                $urandom_range(0, 4) == 0);
        idle();
        for (int i = 0; i < 8; i++) peek("rnd_reg", 3'(i), m_regs[i]);

        // reset with an instruction in flight
        cyc(1, 4'd4, 3'd6, 3'd0, 8'd9, 1, 0);
        do_reset();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
